// File: rtl/msgpu_commands_pkg.sv
// MCU command set shared by the bus front-end and the decoder.
// Command codes, decoder states and the default device ID.
package msgpu_commands_pkg;

  localparam logic [7:0] CMD_GET_ID      = 8'h01;
  localparam logic [7:0] CMD_SET_ADDRESS = 8'h02;
  localparam logic [7:0] CMD_WRITE_DATA  = 8'h03;

  localparam logic [7:0] DEVICE_ID_DEFAULT = 8'hAE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WRITE
  } dec_state_t;

endpackage

// File: rtl/mcu_addr_assembler.sv
// Builds a multi-byte address MSB first in a shadow register.
// The live address only sees the value once the final byte lands.
module mcu_addr_assembler #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  system_clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  shift,
  input  logic [7:0]            byte_in,
  output logic                  commit,
  output logic [ADDR_WIDTH-1:0] commit_addr,
  output logic                  addr_loaded
);

  localparam int ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int CW = 3;

  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] shadow;

  assign commit_addr = ADDR_WIDTH'({shadow, byte_in});
  assign commit = shift && (count == CW'(ADDR_BYTES - 1));

  // Shadow shift, byte count and the registered commit pulse
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      count       <= '0;
      shadow      <= '0;
      addr_loaded <= 1'b0;
    end else begin
      addr_loaded <= commit;
      if (clear || commit) begin
        count <= '0;
      end else if (shift) begin
        count <= count + CW'(1);
      end
      if (shift) begin
        shadow <= commit_addr;
      end
    end
  end

endmodule

// File: rtl/mcu_command_decoder.sv
// Decodes the strobed MCU byte stream into ID responses,
// address loads and auto-incrementing memory writes.
module mcu_command_decoder
  import msgpu_commands_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID  = DEVICE_ID_DEFAULT,
  parameter int         ADDR_WIDTH = 32
) (
  input  logic                  system_clock,
  input  logic                  reset_n,
  input  logic                  cmd_strobe,
  input  logic                  data_strobe,
  input  logic [7:0]            byte_in,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [7:0]            resp_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  addr_loaded,
  output logic                  protocol_error,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  dec_state_t            state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic                  commit;
  logic                  is_get;
  logic                  is_set;
  logic                  is_wr;
  logic                  is_bad;
  logic                  data_ok;
  logic                  addr_shift;
  logic                  wr_accept;
  logic                  wr_hs;
  logic                  wr_busy;

  assign data_ok    = data_strobe && !cmd_strobe;
  assign addr_shift = data_ok && (state == ST_ADDR);
  assign wr_accept  = data_ok && (state == ST_WRITE);
  assign wr_hs      = wr_valid && wr_ready;
  assign wr_busy    = wr_valid && !wr_ready;
  assign addr_inc   = cur_addr + ADDR_ONE;

  // Command byte decode, only meaningful under cmd_strobe
  always_comb begin
    is_get = 1'b0;
    is_set = 1'b0;
    is_wr  = 1'b0;
    is_bad = 1'b0;
    if (cmd_strobe) begin
      unique case (1'b1)
        (byte_in == CMD_GET_ID):      is_get = 1'b1;
        (byte_in == CMD_SET_ADDRESS): is_set = 1'b1;
        (byte_in == CMD_WRITE_DATA):  is_wr  = 1'b1;
        default:                      is_bad = 1'b1;
      endcase
    end
  end

  mcu_addr_assembler #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_asm (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .clear        (is_set),
    .shift        (addr_shift),
    .byte_in      (byte_in),
    .commit       (commit),
    .commit_addr  (commit_addr),
    .addr_loaded  (addr_loaded)
  );

  // Any command aborts; a finished address returns to IDLE
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else if (cmd_strobe) begin
      if (is_set) begin
        state <= ST_ADDR;
      end else if (is_wr) begin
        state <= ST_WRITE;
      end else begin
        state <= ST_IDLE;
      end
    end else if (commit) begin
      state <= ST_IDLE;
    end
  end

  // Current address: new value on commit, +1 per write handshake
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      cur_addr <= '0;
    end else if (commit) begin
      cur_addr <= commit_addr;
    end else if (wr_hs) begin
      cur_addr <= addr_inc;
    end
  end

  // Single-entry write slot; a strobe during handshake refills it
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (wr_accept && !wr_busy) begin
      wr_valid <= 1'b1;
      wr_data  <= byte_in;
      wr_addr  <= wr_hs ? addr_inc : cur_addr;
    end else if (wr_hs) begin
      wr_valid <= 1'b0;
    end
  end

  // ID response held until the front-end takes it
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else if (is_get) begin
      resp_valid <= 1'b1;
      resp_data  <= DEVICE_ID;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      protocol_error <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (is_bad || (cmd_strobe && data_strobe) ||
          (data_ok && (state == ST_IDLE))) begin
        protocol_error <= 1'b1;
      end
      if (wr_accept && wr_busy) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mcu_command_decoder.sv
// Scoreboard bench: a transaction-level model predicts writes,
// responses and flags; a negedge monitor checks the DUT.
module tb_mcu_command_decoder;

  logic        system_clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_strobe = 1'b0;
  logic        data_strobe = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        resp_ready = 1'b0;
  logic        wr_ready = 1'b0;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        addr_loaded;
  logic        protocol_error;
  logic        overflow;

  mcu_command_decoder dut (
    .system_clock   (system_clock),
    .reset_n        (reset_n),
    .cmd_strobe     (cmd_strobe),
    .data_strobe    (data_strobe),
    .byte_in        (byte_in),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .addr_loaded    (addr_loaded),
    .protocol_error (protocol_error),
    .overflow       (overflow)
  );

  always #5 system_clock = ~system_clock;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];

  // model: 0 idle, 1 collecting address bytes, 2 writing
  int          m_mode, n_mode;
  logic [31:0] m_addr, n_addr;
  logic [7:0]  m_bytes[$];
  bit m_pend, m_perr, m_ovf, m_rvalid, m_aload;
  bit n_pend, n_perr, n_ovf, n_rvalid, n_aload;

  bit started = 1'b0;
  bit g_rst = 1'b0;
  bit g_rr = 1'b1;
  bit g_wr = 1'b1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic step(input bit c, input bit d, input logic [7:0] b,
                      input bit rr, input bit wr, input bit rst);
    bit hs;
    if (!rst) begin
      n_mode = 0; n_addr = '0; n_pend = 0; n_perr = 0;
      n_ovf = 0; n_rvalid = 0; n_aload = 0;
      m_bytes.delete(); wq.delete(); rq.delete();
      return;
    end
    hs = m_pend && wr;
    n_mode = m_mode; n_addr = m_addr; n_pend = m_pend;
    n_perr = m_perr; n_ovf = m_ovf; n_aload = 0;
    n_rvalid = (m_rvalid && rr) ? 1'b0 : m_rvalid;
    if (hs) begin
      n_pend = 0;
      n_addr = m_addr + 1;
    end
    if (c) begin
      if (d) n_perr = 1;
      if (b == 8'h01) begin
        if (!(m_rvalid && !rr)) rq.push_back(8'hAE);
        n_rvalid = 1;
        n_mode = 0;
      end else if (b == 8'h02) begin
        m_bytes.delete();
        n_mode = 1;
      end else if (b == 8'h03) begin
        n_mode = 2;
      end else begin
        n_mode = 0;
        n_perr = 1;
      end
    end else if (d) begin
      if (m_mode == 0) begin
        n_perr = 1;
      end else if (m_mode == 1) begin
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
          n_addr = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          n_aload = 1;
          n_mode = 0;
          m_bytes.delete();
        end
      end else if (m_pend && !wr) begin
        n_ovf = 1;
      end else begin
        wq.push_back('{hs ? m_addr + 1 : m_addr, b});
        n_pend = 1;
      end
    end
  endtask

  task automatic drive(input bit c, input bit d, input logic [7:0] b);
    bit rr, wr;
    @(posedge system_clock);
    #1;
    m_mode = n_mode; m_addr = n_addr; m_pend = n_pend;
    m_perr = n_perr; m_ovf = n_ovf; m_rvalid = n_rvalid;
    m_aload = n_aload;
    started = 1'b1;
    rr = g_rst ? g_rr : 1'b0;
    wr = g_rst ? g_wr : 1'b0;
    reset_n = g_rst;
    cmd_strobe = c;
    data_strobe = d;
    byte_in = b;
    resp_ready = rr;
    wr_ready = wr;
    step(c, d, b, rr, wr, g_rst);
  endtask

  task automatic cmd(input logic [7:0] b);
    drive(1'b1, 1'b0, b);
  endtask

  task automatic dat(input logic [7:0] b);
    drive(1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    g_rst = 1'b0;
    idle(1);
    g_rst = 1'b1;
  endtask

  // monitor: per-cycle flags, then scoreboard pops on handshakes
  always @(negedge system_clock) begin
    if (started) begin
      wr_t e;
      chk("wr_valid", 32'(wr_valid), 32'(m_pend));
      chk("resp_valid", 32'(resp_valid), 32'(m_rvalid));
      chk("addr_loaded", 32'(addr_loaded), 32'(m_aload));
      chk("protocol_error", 32'(protocol_error), 32'(m_perr));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (wr_valid && wr_ready) begin
        if (wq.size() == 0) begin
          chk("wr_unexpected", 32'(1), 32'(0));
        end else begin
          e = wq.pop_front();
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", 32'(wr_data), 32'(e.d));
        end
      end
      if (resp_valid && resp_ready) begin
        if (rq.size() == 0) begin
          chk("resp_unexpected", 32'(1), 32'(0));
        end else begin
          chk("resp_data", 32'(resp_data), 32'(rq.pop_front()));
        end
      end
    end
  end

  initial begin
    int r;
    n_mode = 0; n_addr = '0; n_pend = 0; n_perr = 0;
    n_ovf = 0; n_rvalid = 0; n_aload = 0;
    g_rst = 1'b0;
    idle(2);
    g_rst = 1'b1;
    g_rr = 1'b1;
    g_wr = 1'b1;

    cmd(8'h01); idle(3);
    g_rr = 1'b0;
    cmd(8'h01); idle(5);
    g_rr = 1'b1;
    idle(2);

    cmd(8'h02);
    dat(8'h12); dat(8'h34); dat(8'h56); dat(8'h78);
    idle(2);
    cmd(8'h03);
    dat(8'hAA); dat(8'hBB);
    idle(3);

    cmd(8'h02);
    dat(8'hFF); dat(8'hFF); dat(8'hFF); dat(8'hFF);
    cmd(8'h03);
    dat(8'h01); dat(8'h02); dat(8'h03);
    idle(2);

    g_wr = 1'b0;
    dat(8'h11); dat(8'h22);
    idle(2);
    g_wr = 1'b1;
    idle(3);

    cmd(8'h02);
    dat(8'hC0); dat(8'hDE);
    cmd(8'h01);
    idle(3);
    cmd(8'h03);
    dat(8'h33);
    idle(2);

    do_reset();
    dat(8'h55); idle(2);
    do_reset();
    cmd(8'h7F); idle(2);
    do_reset();
    drive(1'b1, 1'b1, 8'h03); idle(2);
    do_reset();
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      g_rr = ($urandom_range(0, 3) != 0);
      g_wr = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 999);
      if (r < 3) do_reset();
      else if (r < 80) cmd(8'h01);
      else if (r < 150) cmd(8'h02);
      else if (r < 230) cmd(8'h03);
      else if (r < 245) cmd(8'($urandom_range(4, 255)));
      else if (r < 260) drive(1'b1, 1'b1, 8'($urandom_range(1, 3)));
      else if (r < 750) dat(8'($urandom_range(0, 255)));
      else idle(1);
    end

    g_rr = 1'b1;
    g_wr = 1'b1;
    idle(6);
    chk("wq_drained", 32'(wq.size()), 32'(0));
    chk("rq_drained", 32'(rq.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
